// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot row decoder with a self-timed row-scan mode.
// DIRECT decodes `in` with one cycle of latency; SCAN sweeps ROWS lines, DWELL cycles each.
module scan_decoder #(
  parameter int N     = 3,
  parameter int ROWS  = 2**N,
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              mode,
  input  logic [N-1:0]      in,
  output logic [2**N-1:0]   out,
  output logic [N-1:0]      row,
  output logic              frame_done
);

  localparam int OUT_W = 2**N;
  localparam int DW    = $clog2(DWELL) + 1;

  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [N-1:0]  ROW_LAST   = N'(ROWS - 1);

  typedef enum logic {
    S_DIRECT,
    S_SCAN
  } state_t;

  state_t            state_q, state_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [N-1:0]      row_q, row_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic              frame_done_q, frame_done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_DIRECT;
      out_q        <= '0;
      row_q        <= '0;
      dwell_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      row_q        <= row_d;
      dwell_q      <= dwell_d;
      frame_done_q <= frame_done_d;
    end
  end

  // The row chosen for this edge is always what gets driven, so out tracks row and stays one-hot.
  always_comb begin
    state_d      = mode ? S_SCAN : S_DIRECT;
    row_d        = row_q;
    dwell_d      = dwell_q;
    frame_done_d = 1'b0;

    if (!mode) begin
      row_d   = in;
      dwell_d = '0;
    end else if (state_q == S_DIRECT) begin
      row_d   = '0;
      dwell_d = '0;
    end else if (ena) begin
      if (dwell_q == DWELL_LAST) begin
        dwell_d = '0;
        if (row_q == ROW_LAST) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + N'(1);
        end
      end else begin
        dwell_d = dwell_q + DW'(1);
      end
    end

    out_d = ena ? (OUT_W'(1) << row_d) : '0;
  end

  assign out        = out_q;
  assign row        = row_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: one default instance for DIRECT mode and
// two small scan configurations (ROWS=3/DWELL=2 and ROWS=4/DWELL=1).
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       mode;
  logic [2:0] in_a;
  logic [1:0] in_b;

  logic [7:0] out_a;
  logic [2:0] row_a;
  logic       fd_a;
  logic [3:0] out_b;
  logic [1:0] row_b;
  logic       fd_b;
  logic [3:0] out_c;
  logic [1:0] row_c;
  logic       fd_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  scan_decoder #(.N(3)) dut_a (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .in(in_a),
    .out(out_a), .row(row_a), .frame_done(fd_a)
  );

  scan_decoder #(.N(2), .ROWS(3), .DWELL(2)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .in(in_b),
    .out(out_b), .row(row_b), .frame_done(fd_b)
  );

  scan_decoder #(.N(2), .ROWS(4), .DWELL(1)) dut_c (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .in(in_b),
    .out(out_c), .row(row_c), .frame_done(fd_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; mode = 1'b0; in_a = 3'd6; in_b = 2'd2;
    step();
    checks++;
    if (out_a !== 8'h00 || row_a !== 3'd0 || fd_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_a: out=%b row=%0d fd=%b, want out=0 row=0 fd=0", out_a, row_a, fd_a);
    end
    checks++;
    if (out_b !== 4'h0 || row_b !== 2'd0 || fd_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_b: out=%b row=%0d fd=%b, want out=0 row=0 fd=0", out_b, row_b, fd_b);
    end
  endtask

  task automatic test_direct();
    logic [7:0] exp_out [8] = '{8'b00000001, 8'b00000010, 8'b00000100, 8'b00001000,
                                8'b00010000, 8'b00100000, 8'b01000000, 8'b10000000};
    rst = 1'b0; ena = 1'b1; mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_a = 3'(i);
      step();
      checks++;
      if (out_a !== exp_out[i] || row_a !== 3'(i)) begin
        errors++;
        $display("[TB] FAIL direct_in%0d: out=%b row=%0d, want out=%b row=%0d", i, out_a, row_a, exp_out[i], i);
      end
    end
  endtask

  task automatic test_direct_disable();
    ena = 1'b0; mode = 1'b0; in_a = 3'd5;
    step();
    checks++;
    if (out_a !== 8'h00 || row_a !== 3'd5) begin
      errors++;
      $display("[TB] FAIL direct_ena0: out=%b row=%0d, want out=00000000 row=5", out_a, row_a);
    end
    ena = 1'b1;
    step();
    checks++;
    if (out_a !== 8'b00100000) begin
      errors++;
      $display("[TB] FAIL direct_reenable: out=%b, want 00100000", out_a);
    end
  endtask

  task automatic test_scan_sweep();
    logic [3:0] exp_out [7] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0001};
    logic       exp_fd  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    rst = 1'b1; ena = 1'b1; mode = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (out_b !== exp_out[i] || fd_b !== exp_fd[i]) begin
        errors++;
        $display("[TB] FAIL scan_sweep_%0d: out=%b fd=%b, want out=%b fd=%b", i, out_b, fd_b, exp_out[i], exp_fd[i]);
      end
    end
  endtask

  task automatic test_scan_pause();
    // advance from (row0,dwell0) to (row1,dwell0)
    step();
    step();
    checks++;
    if (out_b !== 4'b0010 || row_b !== 2'd1) begin
      errors++;
      $display("[TB] FAIL pause_setup: out=%b row=%0d, want out=0010 row=1", out_b, row_b);
    end
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_b !== 4'b0000 || fd_b !== 1'b0 || row_b !== 2'd1) begin
        errors++;
        $display("[TB] FAIL pause_%0d: out=%b fd=%b row=%0d, want out=0000 fd=0 row=1", i, out_b, fd_b, row_b);
      end
    end
    ena = 1'b1;
    step();
    checks++;
    if (out_b !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL resume_hold: out=%b, want 0010", out_b);
    end
    step();
    checks++;
    if (out_b !== 4'b0100 || row_b !== 2'd2) begin
      errors++;
      $display("[TB] FAIL resume_advance: out=%b row=%0d, want out=0100 row=2", out_b, row_b);
    end
  endtask

  task automatic test_reset_mid_scan();
    rst = 1'b1;
    step();
    checks++;
    if (out_b !== 4'b0000 || row_b !== 2'd0 || fd_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midscan_reset: out=%b row=%0d fd=%b, want out=0000 row=0 fd=0", out_b, row_b, fd_b);
    end
    rst = 1'b0;
    step();
    checks++;
    if (out_b !== 4'b0001 || row_b !== 2'd0 || fd_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midscan_reentry: out=%b row=%0d fd=%b, want out=0001 row=0 fd=0", out_b, row_b, fd_b);
    end
  endtask

  task automatic test_dwell1_rotate();
    logic [3:0] exp_out [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic       exp_fd  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    rst = 1'b1; ena = 1'b1; mode = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      checks++;
      if (out_c !== exp_out[i] || fd_c !== exp_fd[i]) begin
        errors++;
        $display("[TB] FAIL rotate_%0d: out=%b fd=%b, want out=%b fd=%b", i, out_c, fd_c, exp_out[i], exp_fd[i]);
      end
    end
  endtask

  task automatic test_mode_toggle();
    step();
    step();
    mode = 1'b0; in_b = 2'd3;
    step();
    checks++;
    if (out_c !== 4'b1000 || row_c !== 2'd3 || fd_c !== 1'b0) begin
      errors++;
      $display("[TB] FAIL toggle_direct: out=%b row=%0d fd=%b, want out=1000 row=3 fd=0", out_c, row_c, fd_c);
    end
    mode = 1'b1;
    step();
    checks++;
    if (out_c !== 4'b0001 || row_c !== 2'd0 || fd_c !== 1'b0) begin
      errors++;
      $display("[TB] FAIL toggle_restart: out=%b row=%0d fd=%b, want out=0001 row=0 fd=0", out_c, row_c, fd_c);
    end
    step();
    checks++;
    if (out_c !== 4'b0010 || row_c !== 2'd1) begin
      errors++;
      $display("[TB] FAIL toggle_continue: out=%b row=%0d, want out=0010 row=1", out_c, row_c);
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; mode = 1'b0; in_a = '0; in_b = '0;
    #2;
    test_reset();
    test_direct();
    test_direct_disable();
    test_scan_sweep();
    test_scan_pause();
    test_reset_mid_scan();
    test_dwell1_rotate();
    test_mode_toggle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with an optional self-timed row-scan mode.
- In DIRECT mode it decodes `in` like a combinational decoder, but with one-cycle latency.
- In SCAN mode an internal counter walks the one-hot output across ROWS lines, holding each line for DWELL cycles and pulsing `frame_done` once per full sweep.
- It drives row selects for the Game of Life LED-matrix display path and replaces ad-hoc fixed-width decoders there.

Parameters:
- N, 3, select width; output width is 2^N.
- ROWS, 2**N, number of rows swept in SCAN mode; legal range 1..2^N.
- DWELL, 4, cycles each row is held in SCAN mode; legal range >= 1; counter width is $clog2(DWELL)+1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  enable; when low, output is blanked and the scan pauses.
- mode  input  1  0 = DIRECT, 1 = SCAN.
- in  input  N  row select in DIRECT mode; ignored in SCAN mode.
- out  output  2^N  registered one-hot (or all-zero) row drive.
- row  output  N  registered index of the active row.
- frame_done  output  1  one-cycle pulse when a SCAN sweep completes.

Behaviour:
- Reset, sampled on the rising `clk` edge while `rst`=1:
  - out=0, row=0, frame_done=0.
  - Dwell counter=0, FSM=S_DIRECT, mode_q=0.
  - `rst` dominates all other inputs, including in mid-scan.
- FSM states are S_DIRECT and S_SCAN. Next state is `mode`, evaluated every edge regardless of `ena`.
- S_DIRECT, with one-cycle latency:
  - out <= ena ? (1 << in) : 0.
  - row <= in.
  - Dwell counter <= 0.
  - frame_done <= 0.
- Entering SCAN (mode=1 while mode_q=0) takes effect on that edge:
  - row <= 0, dwell <= 0.
  - out <= ena ? 1 : 0.
  - frame_done <= 0.
- S_SCAN with ena=1:
  - Dwell increments each edge.
  - When dwell == DWELL-1: dwell <= 0 and row <= (row == ROWS-1) ? 0 : row+1.
  - out is always updated to onehot(next row), so out == 1 << row after every edge.
  - frame_done <= 1 only on the edge where row wraps from ROWS-1 to 0; otherwise 0.
- S_SCAN with ena=0:
  - row and dwell hold their values.
  - out <= 0 and frame_done <= 0.
  - When ena returns high, scanning resumes from the held row and dwell; out shows that row on the first enabled edge.
- DWELL=1: row advances every enabled cycle.
- ROWS=1: row stays 0, and frame_done pulses every DWELL enabled cycles.
- Leaving SCAN for DIRECT takes effect on the next edge; out reflects `in`.
- out bits at or above ROWS are never set in SCAN mode.
- out is never multi-hot in any state.

Test Plan:
- Defaults (N=3). Reset, then DIRECT with ena=1 and in=0..7 stepped each cycle -> one cycle later out = 8'b00000001, 8'b00000010, ... 8'b10000000, with row = in.
- DIRECT, ena=0 with in=5 -> out=0 and row=5 after the next edge. Then ena=1 -> out=8'b00100000 on the following edge.
- N=2, ROWS=3, DWELL=2, SCAN from reset, ena=1 -> out sequence 0001,0001,0010,0010,0100,0100,0001... frame_done high exactly on the edge where out returns to 0001, i.e. one pulse every 6 cycles.
- Same config, ena dropped for 3 cycles while row=1 and dwell=0:
  - out=0 during the pause; frame_done never asserts during the pause.
  - After re-enable, out=0010 for one more cycle, then 0100.
- rst asserted mid-scan at row=2 -> next edge gives out=0, row=0, frame_done=0. With mode still 1, the first post-reset edge enters SCAN with out=0001.
- DWELL=1, ROWS=4, N=2 -> out rotates 0001,0010,0100,1000 every cycle, frame_done on every 4th edge. Toggling mode 1->0->1 mid-sweep restarts at row 0.
